// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bus: register fields observed from the pipeline and the
// stall / flush / forwarding controls returned to it.
// master = pipeline datapath side, slave = hazard unit side.
interface pipeline_hazard_unit_if #(
  parameter int REG_ADDR_W = 4
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_redirect;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  mem_reg_write;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  pc_stall;
  logic                  ifid_stall;
  logic                  idex_bubble;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_reg_write,
           ex_mem_read, ex_redirect, mem_rd, wb_rd, mem_reg_write,
           wb_reg_write, ex_rs, ex_rt,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
           fwd_a, fwd_b, busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_reg_write,
           ex_mem_read, ex_redirect, mem_rd, wb_rd, mem_reg_write,
           wb_reg_write, ex_rs, ex_rt,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
           fwd_a, fwd_b, busy
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard / forwarding controller for the 24-bit-instruction pipeline.
// Load-use stalls, multi-cycle redirect flushes and ALU operand forwarding.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating perf counters
// (stall_cycles, flush_cycles, fwd_events).
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W     = 4,
  parameter int BRANCH_PENALTY = 2,
`ifdef HAZ_PERF_CNT_EN
  parameter int CNT_W          = 16,
`endif
  parameter int LOAD_STALLS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        flush_cycles,
  output logic [CNT_W-1:0]        fwd_events,
`endif
  pipeline_hazard_unit_if.slave   hz
);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

  localparam logic [1:0] FLUSH_CNT = 2'(BRANCH_PENALTY - 1);
  localparam logic [1:0] STALL_CNT = 2'(LOAD_STALLS - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       stall, bubble, flush_if, flush_ex;
  logic       hazard_lu;
  logic [1:0] fwd_a, fwd_b;

  // Younger EX/MEM producer beats MEM/WB; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] mrd,
    input logic                  mwr,
    input logic [REG_ADDR_W-1:0] wrd,
    input logic                  wwr
  );
    if (mwr && mrd != '0 && mrd == src)      return 2'b01;
    else if (wwr && wrd != '0 && wrd == src) return 2'b10;
    else                                     return 2'b00;
  endfunction

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  assign hazard_lu = hz.ex_mem_read && hz.ex_reg_write && hz.ex_rd != '0 &&
                     ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) ||
                      (hz.id_uses_rt && hz.id_rt == hz.ex_rd));

  // Next-state and same-cycle control decode; redirect outranks everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush_if = 1'b0;
    flush_ex = 1'b0;
    if (hz.ex_redirect) begin
      flush_if = 1'b1;
      flush_ex = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_CNT;
      end else begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hazard_lu) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_STALLS > 1) begin
              state_d = LSTALL;
              cnt_d   = STALL_CNT;
            end
          end
        end
        LSTALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        FLUSH: begin
          flush_if = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // FSM state and sequence counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a = fwd_sel(hz.ex_rs, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
  assign fwd_b = fwd_sel(hz.ex_rt, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);

  // Every control is forced quiet while reset is held.
  assign hz.pc_stall    = stall    & ~reset;
  assign hz.ifid_stall  = stall    & ~reset;
  assign hz.idex_bubble = bubble   & ~reset;
  assign hz.ifid_flush  = flush_if & ~reset;
  assign hz.idex_flush  = flush_ex & ~reset;
  assign hz.fwd_a       = reset ? 2'b00 : fwd_a;
  assign hz.fwd_b       = reset ? 2'b00 : fwd_b;
  assign hz.busy        = (state_q != RUN) & ~reset;

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters driven from the gated outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (hz.pc_stall)                     stall_cycles <= sat_inc(stall_cycles);
      if (hz.ifid_flush)                   flush_cycles <= sat_inc(flush_cycles);
      if (hz.fwd_a != 2'b00 || hz.fwd_b != 2'b00) fwd_events <= sat_inc(fwd_events);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: two instances share stimulus,
// A (BRANCH_PENALTY=2, LOAD_STALLS=1) and B (BRANCH_PENALTY=3, LOAD_STALLS=2).
// Control outputs are packed as {busy, pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush}.
module tb_pipeline_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_ADDR_W(4)) ifa ();
  pipeline_hazard_unit_if #(.REG_ADDR_W(4)) ifb ();

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] sc_a, fc_a, fe_a, sc_b, fc_b, fe_b;
`endif

  pipeline_hazard_unit #(.REG_ADDR_W(4), .BRANCH_PENALTY(2), .LOAD_STALLS(1)) dut_a (
    .clk(clk), .reset(reset),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(sc_a), .flush_cycles(fc_a), .fwd_events(fe_a),
`endif
    .hz(ifa.slave)
  );

  pipeline_hazard_unit #(.REG_ADDR_W(4), .BRANCH_PENALTY(3), .LOAD_STALLS(2)) dut_b (
    .clk(clk), .reset(reset),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(sc_b), .flush_cycles(fc_b), .fwd_events(fe_b),
`endif
    .hz(ifb.slave)
  );

  assign ifb.id_rs         = ifa.id_rs;
  assign ifb.id_rt         = ifa.id_rt;
  assign ifb.id_uses_rs    = ifa.id_uses_rs;
  assign ifb.id_uses_rt    = ifa.id_uses_rt;
  assign ifb.ex_rd         = ifa.ex_rd;
  assign ifb.ex_reg_write  = ifa.ex_reg_write;
  assign ifb.ex_mem_read   = ifa.ex_mem_read;
  assign ifb.ex_redirect   = ifa.ex_redirect;
  assign ifb.mem_rd        = ifa.mem_rd;
  assign ifb.wb_rd         = ifa.wb_rd;
  assign ifb.mem_reg_write = ifa.mem_reg_write;
  assign ifb.wb_reg_write  = ifa.wb_reg_write;
  assign ifb.ex_rs         = ifa.ex_rs;
  assign ifb.ex_rt         = ifa.ex_rt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl_a();
    return {ifa.busy, ifa.pc_stall, ifa.ifid_stall, ifa.idex_bubble, ifa.ifid_flush, ifa.idex_flush};
  endfunction

  function automatic logic [5:0] ctl_b();
    return {ifb.busy, ifb.pc_stall, ifb.ifid_stall, ifb.idex_bubble, ifb.ifid_flush, ifb.idex_flush};
  endfunction

  task automatic clear();
    ifa.id_rs = '0; ifa.id_rt = '0; ifa.id_uses_rs = 1'b0; ifa.id_uses_rt = 1'b0;
    ifa.ex_rd = '0; ifa.ex_reg_write = 1'b0; ifa.ex_mem_read = 1'b0; ifa.ex_redirect = 1'b0;
    ifa.mem_rd = '0; ifa.wb_rd = '0; ifa.mem_reg_write = 1'b0; ifa.wb_reg_write = 1'b0;
    ifa.ex_rs = '0; ifa.ex_rt = '0;
  endtask

  task automatic load_use(input logic [3:0] rd);
    ifa.ex_mem_read = 1'b1; ifa.ex_reg_write = 1'b1; ifa.ex_rd = rd;
    ifa.id_rs = 4'd3; ifa.id_uses_rs = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear();
    tick();
    // Outputs held low under reset even with a hazard and forwarding match present
    load_use(4'd3);
    ifa.mem_rd = 4'd5; ifa.mem_reg_write = 1'b1; ifa.ex_rs = 4'd5;
    #1;
    chk("rst_ctl_a", 32'(ctl_a()), 32'b000000);
    chk("rst_ctl_b", 32'(ctl_b()), 32'b000000);
    chk("rst_fwd_a", 32'(ifa.fwd_a), 32'd0);
    tick();
    reset = 1'b0;
    clear();

    // T1: load-use, single stall on A, two-cycle stall on B
    load_use(4'd3);
    #1;
    chk("t1_lu_a", 32'(ctl_a()), 32'b011100);
    chk("t1_lu_b", 32'(ctl_b()), 32'b011100);
    tick();
    clear();
    #1;
    chk("t1_after_a", 32'(ctl_a()), 32'b000000);
    chk("t1_lstall_b", 32'(ctl_b()), 32'b111100);
    tick();
    chk("t1_done_b", 32'(ctl_b()), 32'b000000);

    // T2: load to r0 is never a hazard
    load_use(4'd0);
    #1;
    chk("t2_r0_a", 32'(ctl_a()), 32'b000000);
    chk("t2_r0_b", 32'(ctl_b()), 32'b000000);
    tick();
    clear();

    // T3: redirect pulse
    ifa.ex_redirect = 1'b1;
    #1;
    chk("t3_c0_a", 32'(ctl_a()), 32'b000011);
    chk("t3_c0_b", 32'(ctl_b()), 32'b000011);
    tick();
    clear();
    #1;
    chk("t3_c1_a", 32'(ctl_a()), 32'b100010);
    chk("t3_c1_b", 32'(ctl_b()), 32'b100010);
    tick();
    chk("t3_c2_a", 32'(ctl_a()), 32'b000000);
    chk("t3_c2_b", 32'(ctl_b()), 32'b100010);
    tick();
    chk("t3_c3_b", 32'(ctl_b()), 32'b000000);

    // T4a: load-use and redirect together -> flush only
    load_use(4'd3);
    ifa.ex_redirect = 1'b1;
    #1;
    chk("t4_both_a", 32'(ctl_a()), 32'b000011);
    chk("t4_both_b", 32'(ctl_b()), 32'b000011);
    tick();
    clear();
    tick();
    tick();
    chk("t4_idle_a", 32'(ctl_a()), 32'b000000);
    chk("t4_idle_b", 32'(ctl_b()), 32'b000000);

    // T4b: redirect while B is in LSTALL
    load_use(4'd3);
    tick();
    clear();
    ifa.ex_redirect = 1'b1;
    #1;
    chk("t4_lsredir_b", 32'(ctl_b()), 32'b100011);
    chk("t4_redir_a", 32'(ctl_a()), 32'b000011);
    tick();
    clear();
    #1;
    chk("t4_flush_b", 32'(ctl_b()), 32'b100010);
    chk("t4_flush_a", 32'(ctl_a()), 32'b100010);

    // T6: reset while B is in FLUSH with cnt=2
    reset = 1'b1;
    #1;
    chk("t6_rsthi_b", 32'(ctl_b()), 32'b000000);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_post_b", 32'(ctl_b()), 32'b000000);
    chk("t6_post_a", 32'(ctl_a()), 32'b000000);
`ifdef HAZ_PERF_CNT_EN
    chk("t6_sc_b", 32'(sc_b), 32'd0);
    chk("t6_fc_b", 32'(fc_b), 32'd0);
    chk("t6_fe_a", 32'(fe_a), 32'd0);
`endif
    tick();
    chk("t6_idle_b", 32'(ctl_b()), 32'b000000);

    // T5: forwarding selects
    ifa.mem_rd = 4'd5; ifa.wb_rd = 4'd5;
    ifa.mem_reg_write = 1'b1; ifa.wb_reg_write = 1'b1;
    ifa.ex_rs = 4'd5; ifa.ex_rt = 4'd0;
    #1;
    chk("t5_both_a", 32'(ifa.fwd_a), 32'b01);
    chk("t5_both_b", 32'(ifa.fwd_b), 32'b00);
    ifa.mem_reg_write = 1'b0;
    #1;
    chk("t5_wb_a", 32'(ifa.fwd_a), 32'b10);
    ifa.mem_reg_write = 1'b1; ifa.mem_rd = 4'd0; ifa.wb_rd = 4'd0;
    ifa.ex_rs = 4'd0;
    #1;
    chk("t5_r0_a", 32'(ifa.fwd_a), 32'b00);
    ifa.mem_rd = 4'd5; ifa.wb_rd = 4'd6; ifa.ex_rs = 4'd6; ifa.ex_rt = 4'd5;
    #1;
    chk("t5_split_a", 32'(ifa.fwd_a), 32'b10);
    chk("t5_split_b", 32'(ifa.fwd_b), 32'b01);
    chk("t5_ctl_a", 32'(ctl_a()), 32'b000000);
`ifdef HAZ_PERF_CNT_EN
    tick();
    chk("t5_fe_a", 32'(fe_a), 32'd1);
`endif
    clear();

`ifdef HAZ_PERF_CNT_EN
    load_use(4'd3);
    tick();
    clear();
    #1;
    chk("perf_sc_a", 32'(sc_a), 32'd1);
    chk("perf_fc_a", 32'(fc_a), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
